// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 target with a small local register file.
// Frames are a command byte (MSB=1 write, 0 read; low bits = register index)
// followed by one data byte. sclk/cs_n/mosi are oversampled in the pclk domain.
// Optional feature: define SPI_SLV_AUTOINC_EN to enable burst transfers with
// an auto-incrementing register index that wraps from DEPTH-1 to 0.
// SYNC_STAGES must be at least 2.
//
// state  | meaning
// S_IDLE | cs_n high, waiting for a frame to start
// S_ADDR | shifting in the command/address byte
// S_DATA | shifting the data byte in (write) or out on miso (read)
// S_DONE | byte complete, ignoring sclk until cs_n rises
module spi_slave_regs #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             pclk_i,
    input  logic             prst_i,
    input  logic             sclk_i,
    input  logic             cs_n_i,
    input  logic             mosi_i,
    output logic             miso_o,
    output logic             rx_valid_o,
    output logic [WIDTH-2:0] rx_addr_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             frame_err_o,
    output logic             busy_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = WIDTH - 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t                 state;
    logic [CW-1:0]          bit_cnt;
    logic [WIDTH-2:0]       shift_in;
    logic [WIDTH-1:0]       shift_out;
    logic                   cmd_wr;
    logic [IW-1:0]          index;
    logic                   miso_q, rx_valid_q, frame_err_q;
    logic [IW-1:0]          rx_addr_q;
    logic [WIDTH-1:0]       rx_data_q;
    logic [WIDTH-1:0]       mem [DEPTH];
`ifdef SPI_SLV_AUTOINC_EN
    logic                   burst;
    logic [IW-1:0]          index_inc;
`endif

    logic [WIDTH-1:0]       next_byte;
    logic                   last_bit;

    function automatic logic idx_ok(input logic [IW-1:0] i);
        return 32'(i) < 32'(DEPTH);
    endfunction

    function automatic logic [WIDTH-1:0] read_mem(input logic [IW-1:0] i);
        return idx_ok(i) ? mem[i[AW-1:0]] : '0;
    endfunction

    // Synchronizers plus one extra flop for edge detection; idle values sclk=0, cs_n=1
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    assign next_byte = {shift_in, mosi_s};
    assign last_bit  = (bit_cnt == CW'(WIDTH - 1));

`ifdef SPI_SLV_AUTOINC_EN
    assign index_inc = (32'(index) == 32'(DEPTH - 1)) ? '0 : index + 1'b1;
`endif

    // Frame FSM, register file and all registered outputs
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shift_in    <= '0;
            shift_out   <= '0;
            cmd_wr      <= 1'b0;
            index       <= '0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_addr_q   <= '0;
            rx_data_q   <= '0;
            frame_err_q <= 1'b0;
`ifdef SPI_SLV_AUTOINC_EN
            burst       <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    miso_q  <= 1'b0;
                    bit_cnt <= '0;
`ifdef SPI_SLV_AUTOINC_EN
                    burst   <= 1'b0;
`endif
                    if (cs_fall) state <= S_ADDR;
                end
                S_ADDR: begin
                    if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        miso_q      <= 1'b0;
                        state       <= S_IDLE;
                    end else if (sclk_rise) begin
                        shift_in <= next_byte[WIDTH-2:0];
                        if (last_bit) begin
                            cmd_wr    <= next_byte[WIDTH-1];
                            index     <= next_byte[IW-1:0];
                            shift_out <= next_byte[WIDTH-1] ? '0 : read_mem(next_byte[IW-1:0]);
                            bit_cnt   <= '0;
                            state     <= S_DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (cs_rise) begin
                        // a burst that ends cleanly on a byte boundary is not an error
`ifdef SPI_SLV_AUTOINC_EN
                        frame_err_q <= !(burst && (bit_cnt == '0));
`else
                        frame_err_q <= 1'b1;
`endif
                        miso_q      <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        if (sclk_fall) begin
                            miso_q    <= shift_out[WIDTH-1];
                            shift_out <= shift_out << 1;
                        end
                        if (sclk_rise) begin
                            shift_in <= next_byte[WIDTH-2:0];
                            if (last_bit) begin
                                if (cmd_wr && idx_ok(index)) begin
                                    mem[index[AW-1:0]] <= next_byte;
                                    rx_valid_q         <= 1'b1;
                                    rx_addr_q          <= index;
                                    rx_data_q          <= next_byte;
                                end
                                bit_cnt <= '0;
                                state   <= S_DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (cs_rise) begin
                        miso_q <= 1'b0;
                        state  <= S_IDLE;
                    end
`ifdef SPI_SLV_AUTOINC_EN
                    else begin
                        index     <= index_inc;
                        shift_out <= cmd_wr ? '0 : read_mem(index_inc);
                        burst     <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= S_DATA;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign miso_o      = miso_q;
    assign rx_valid_o  = rx_valid_q;
    assign rx_addr_o   = rx_addr_q;
    assign rx_data_o   = rx_data_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state != S_IDLE);

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: table of full frames plus hand-written
// abort, simultaneous-edge, reset-mid-frame and burst sequences.
module tb_spi_slave_regs;

    localparam int HALF = 6;

    logic       pclk = 1'b0;
    logic       prst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, rx_valid, frame_err, busy;
    logic [6:0] rx_addr;
    logic [7:0] rx_data;

    int         tests = 0;
    int         fails = 0;
    int         n_valid = 0;
    int         n_err = 0;

    spi_slave_regs #(.WIDTH(8), .DEPTH(8), .SYNC_STAGES(2)) dut (
        .pclk_i      (pclk),
        .prst_i      (prst),
        .sclk_i      (sclk),
        .cs_n_i      (cs_n),
        .mosi_i      (mosi),
        .miso_o      (miso),
        .rx_valid_o  (rx_valid),
        .rx_addr_o   (rx_addr),
        .rx_data_o   (rx_data),
        .frame_err_o (frame_err),
        .busy_o      (busy)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (rx_valid)  n_valid <= n_valid + 1;
        if (frame_err) n_err   <= n_err + 1;
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        int         exp_valid;
        logic [6:0] exp_addr;
        logic [7:0] exp_data;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic send_bit(input logic b, output logic m);
        mosi = b;
        wait_clk(HALF);
        m    = miso;
        sclk = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
    endtask

    // Sends the low nbits of bits MSB first in one cs window; cap holds miso
    // as seen just before each of the data-phase rises (bits 8..15).
    task automatic xfer(input logic [31:0] bits, input int nbits, input bit cs_with_last,
                        output logic [7:0] cap);
        logic m;
        cap  = 8'h00;
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            if (cs_with_last && i == nbits - 1) begin
                mosi = bits[nbits-1-i];
                wait_clk(HALF);
                sclk = 1'b1;
                cs_n = 1'b1;
                wait_clk(HALF);
                sclk = 1'b0;
            end else begin
                send_bit(bits[nbits-1-i], m);
                if (i >= 8 && i < 16) cap = {cap[6:0], m};
            end
        end
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic read_chk(input logic [7:0] cmd, input logic [7:0] exp, input string name);
        logic [7:0] cap;
        int v0;
        v0 = n_valid;
        xfer({16'h0, cmd, 8'h00}, 16, 1'b0, cap);
        chk({name, "_miso"}, int'(cap), int'(exp));
        chk({name, "_novalid"}, n_valid - v0, 0);
    endtask

    initial begin
        logic [7:0] cap;
        logic       m;
        int         v0, e0;

        vt[0]  = '{8'h85, 8'h3C, 1, 7'd5, 8'h3C, 8'h00};
        vt[1]  = '{8'h05, 8'h00, 0, 7'd0, 8'h00, 8'h3C};
        vt[2]  = '{8'h83, 8'hA5, 1, 7'd3, 8'hA5, 8'h00};
        vt[3]  = '{8'h03, 8'h00, 0, 7'd0, 8'h00, 8'hA5};
        vt[4]  = '{8'hFF, 8'h77, 0, 7'd0, 8'h00, 8'h00};
        vt[5]  = '{8'h7F, 8'h00, 0, 7'd0, 8'h00, 8'h00};
        vt[6]  = '{8'h02, 8'h00, 0, 7'd0, 8'h00, 8'h00};
        vt[7]  = '{8'h80, 8'hFF, 1, 7'd0, 8'hFF, 8'h00};
        vt[8]  = '{8'h00, 8'h00, 0, 7'd0, 8'h00, 8'hFF};
        vt[9]  = '{8'h87, 8'h81, 1, 7'd7, 8'h81, 8'h00};
        vt[10] = '{8'h07, 8'h00, 0, 7'd0, 8'h00, 8'h81};
        vt[11] = '{8'h08, 8'h00, 0, 7'd0, 8'h00, 8'h00};

        wait_clk(3);
        chk("rst_miso", int'(miso), 0);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_addr", int'(rx_addr), 0);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_err", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
        prst = 1'b0;
        wait_clk(4);

        for (int i = 0; i < 12; i++) begin
            v0 = n_valid;
            e0 = n_err;
            xfer({16'h0, vt[i].cmd, vt[i].data}, 16, 1'b0, cap);
            chk($sformatf("vec%0d_valid", i), n_valid - v0, vt[i].exp_valid);
            chk($sformatf("vec%0d_err", i), n_err - e0, 0);
            chk($sformatf("vec%0d_miso", i), int'(cap), int'(vt[i].exp_miso));
            chk($sformatf("vec%0d_busy", i), int'(busy), 0);
            if (vt[i].exp_valid != 0) begin
                chk($sformatf("vec%0d_addr", i), int'(rx_addr), int'(vt[i].exp_addr));
                chk($sformatf("vec%0d_data", i), int'(rx_data), int'(vt[i].exp_data));
            end
        end

        // cs_n rises after 11 sclk rises of a write to index 2
        v0 = n_valid;
        e0 = n_err;
        xfer(32'h8211 >> 5, 11, 1'b0, cap);
        chk("abort_err", n_err - e0, 1);
        chk("abort_valid", n_valid - v0, 0);
        read_chk(8'h02, 8'h00, "abort_mem2");

        // cs_n rise coincides with the final sclk rise: abort wins
        v0 = n_valid;
        e0 = n_err;
        xfer(32'h8499, 16, 1'b1, cap);
        chk("simul_err", n_err - e0, 1);
        chk("simul_valid", n_valid - v0, 0);
        read_chk(8'h04, 8'h00, "simul_mem4");

        // reset pulse after 6 address bits of 0x81
        e0 = n_err;
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 6; i++) send_bit((i == 0) ? 1'b1 : 1'b0, m);
        wait_clk(2);
        chk("midrst_busy_before", int'(busy), 1);
        prst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_addr", int'(rx_addr), 0);
        chk("midrst_data", int'(rx_data), 0);
        chk("midrst_miso", int'(miso), 0);
        @(negedge pclk);
        cs_n = 1'b1;
        sclk = 1'b0;
        prst = 1'b0;
        wait_clk(8);
        chk("midrst_noerr", n_err - e0, 0);
        read_chk(8'h05, 8'h00, "midrst_mem5_cleared");
        v0 = n_valid;
        xfer(32'h815A, 16, 1'b0, cap);
        chk("midrst_wr_valid", n_valid - v0, 1);
        chk("midrst_wr_addr", int'(rx_addr), 1);
        chk("midrst_wr_data", int'(rx_data), 8'h5A);
        read_chk(8'h01, 8'h5A, "midrst_mem1");

        // three bytes in one cs window starting at index 7
        v0 = n_valid;
        e0 = n_err;
        xfer(32'h870102, 24, 1'b0, cap);
        chk("burst_err", n_err - e0, 0);
`ifdef SPI_SLV_AUTOINC_EN
        chk("burst_valid", n_valid - v0, 2);
        chk("burst_last_data", int'(rx_data), 8'h02);
        chk("burst_last_addr", int'(rx_addr), 0);
        read_chk(8'h07, 8'h01, "burst_mem7");
        read_chk(8'h00, 8'h02, "burst_mem0");
`else
        chk("burst_valid", n_valid - v0, 1);
        chk("burst_last_data", int'(rx_data), 8'h01);
        chk("burst_last_addr", int'(rx_addr), 7);
        read_chk(8'h07, 8'h01, "burst_mem7");
        read_chk(8'h00, 8'h00, "burst_mem0");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
- Downstream SPI target that consumes the serial stream produced by the team's SPI controller (sclk/mosi/cs) and returns read data on miso.
- Each frame is 16 bits: an 8-bit address/command byte followed by an 8-bit data byte. Writes go into a small local register file; reads return register contents.
- All SPI inputs are oversampled in the pclk domain. The block has one clock and serves as bench target and on-chip peripheral front end.

Parameters:
- WIDTH, 8, address and data byte width in bits.
- DEPTH, 8, number of local registers; valid indices are 0..DEPTH-1.
- SYNC_STAGES, 2, synchronizer flops on sclk_i, cs_n_i and mosi_i.

Ports:
- pclk_i  input  1  system clock; all logic is on its rising edge.
- prst_i  input  1  reset, asynchronous and active-high.
- sclk_i  input  1  SPI clock from the controller (mode 0: idle low).
- cs_n_i  input  1  chip select, active-low; one bit of the controller's cs_o.
- mosi_i  input  1  serial data in, MSB first.
- miso_o  output  1  serial data out, MSB first.
- rx_valid_o  output  1  one-cycle pulse when a complete write frame is received.
- rx_addr_o  output  WIDTH-1  register index of the last completed frame.
- rx_data_o  output  WIDTH  data byte of the last completed write frame.
- frame_err_o  output  1  one-cycle pulse when cs_n rises mid-frame.
- busy_o  output  1  high while the FSM is not in S_IDLE.

Behaviour:
- Reset (async, prst_i=1):
  - Outputs: miso_o=0, rx_valid_o=0, rx_addr_o=0, rx_data_o=0, frame_err_o=0, busy_o=0.
  - State: all registers=0, FSM=S_IDLE, bit counter=0, synchronizers cleared to sclk=0, cs_n=1.
  - Reset asserted mid-frame aborts the frame with no write and no error pulse.
- Synchronization and edges:
  - Each of sclk/cs_n/mosi passes through SYNC_STAGES flops.
  - Rise and fall are detected against a third flop, giving sync+edge latency of SYNC_STAGES+1 pclk.
  - Requirement on the driver: sclk high and low phases are each >= SYNC_STAGES+2 pclk cycles. Faster sclk is out of spec and its behaviour is undefined.
- Mode 0 timing: mosi is sampled on detected sclk rise; miso is updated on detected sclk fall.
- Command byte format: bit[WIDTH-1]=1 means write, 0 means read; bits[WIDTH-2:0] hold the register index.
- FSM states and transitions:
  - S_IDLE: wait for cs_n fall, then clear the bit counter and go to S_ADDR. sclk edges are ignored while cs_n is high.
  - S_ADDR: shift WIDTH bits in on sclk rises. After the WIDTH-th rise, latch cmd and index and go to S_DATA.
    - On a read, load the shift-out register with mem[index], or 0x00 if index >= DEPTH.
    - On the next sclk fall, drive its MSB on miso_o.
  - S_DATA:
    - Write: shift WIDTH bits in.
    - Read: shift out on falls while still shifting mosi in, which is ignored.
    - After the WIDTH-th rise, go to S_DONE.
    - Write with index < DEPTH: mem[index] <= data. Pulse rx_valid_o exactly 1 cycle and update rx_addr_o/rx_data_o in the same cycle.
    - Write with index >= DEPTH: no store and no rx_valid_o.
    - Read: no rx_valid_o.
  - S_DONE: ignore further sclk edges (see macro). cs_n rise returns to S_IDLE.
- Abort: cs_n rise in S_ADDR or S_DATA gives a frame_err_o 1-cycle pulse, no store, and a return to S_IDLE.
- Simultaneous events: cs_n rise detected in the same cycle as the final sclk rise means cs wins, so the frame aborts.
- miso_o: returns to 0 on entry to S_IDLE and holds 0 during S_ADDR.
- busy_o: 0 only in S_IDLE.

Optional Feature:
- Macro: SPI_SLV_AUTOINC_EN.
- When defined:
  - In S_DONE with cs_n still low, go directly back to S_DATA for a burst with index+1.
  - The index wraps from DEPTH-1 to 0.
  - Each byte is a new store/rx_valid_o for writes, or a new mem load for reads.
  - cs_n rise in the middle of a burst byte raises frame_err_o; bytes already completed stay stored.
- When undefined: extra bytes after the first data byte are ignored until cs_n rises.

Test Plan:
- Write frame 0x85 then 0x3C, cs_n low for 16 sclk cycles → rx_valid_o pulses once with rx_addr_o=5, rx_data_o=0x3C. A subsequent read of index 5 returns 0x3C.
- Write 0x83/0xA5, then read frame 0x03/0x00 → miso_o shifts 1,0,1,0,0,1,0,1 on the 8 data-phase falls, and no rx_valid_o pulse occurs.
- Write 0x82/0x11, then raise cs_n after 11 sclk rises → frame_err_o pulses once and mem[2] is unchanged (0x00 after reset).
- Write 0xFF/0x77 (index 0x7F >= DEPTH) → no rx_valid_o, no register changes. Read 0x7F → miso_o all zeros.
- Assert prst_i for 1 pclk after 6 address bits → all outputs return to 0 immediately (async). Next full frame 0x81/0x5A is stored correctly in mem[1].
- With SPI_SLV_AUTOINC_EN: frame 0x87 then 0x01,0x02 in one cs → mem[7]=0x01, mem[0]=0x02 (wrap), two rx_valid_o pulses. Without the macro: only mem[7]=0x01.
